pwm_ramp_sched: RTL
===================

PWM_RAMP_SCHED -- requirements
Module: pwm_ramp_sched

Interface
REQ-001 SHALL have parameter NCH, default 3, meaning number of motor channels serviced; the only supported value is 3.
REQ-002 SHALL have parameter RSTSTEP, default 8'h01, meaning the reset value of the step register.
REQ-003 SHALL have port clk, input, 1 bit: system clock; all state changes on its rising edge.
REQ-004 SHALL have port resetn, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port tick, input, 1 bit: one-cycle ramp-step request pulse.
REQ-006 SHALL have port wrtdata, input, 8 bits: write data bus for target and step loads.
REQ-007 SHALL have port tgtld, input, 3 bits: one-hot per-channel target load strobe; captures wrtdata into tgt[i].
REQ-008 SHALL have port stepld, input, 1 bit: step register load strobe; captures wrtdata.
REQ-009 SHALL have port clrovr, input, 1 bit: clears the ovr flag.
REQ-010 SHALL have port pwmdata, output, 8 bits: duty value to channel PWM load bus.
REQ-011 SHALL have port pwmld, output, 3 bits: one-hot, one-cycle PWM load pulse per channel.
REQ-012 SHALL have port busy, output, 1 bit: high while the FSM is not in IDLE.
REQ-013 SHALL have port attarget, output, 3 bits: bit i high when cur[i] equals tgt[i].
REQ-014 SHALL have port ovr, output, 1 bit: sticky tick-overrun flag.

Function
REQ-015 SHALL hold 8-bit registers cur[0..2], tgt[0..2] and step, and use one shared compare/adder path, time-multiplexed across channels.
REQ-016 SHALL implement the FSM states IDLE, SVC0, SVC1 and SVC2, with transitions IDLE->SVC0 on tick (or on a pending tick), then SVC0->SVC1->SVC2->IDLE, one cycle per state.
REQ-017 In SVCi, when cur[i]!=tgt[i], the block SHALL compute the next value, write it to cur[i], and present pwmdata=next and pwmld=(1<<i) on the following cycle, for exactly one cycle.
REQ-018 In SVCi, when cur[i]==tgt[i], the block SHALL leave cur[i] unchanged and assert no pwmld bit for channel i.
REQ-019 The next value SHALL be computed as follows, unsigned, with 9-bit differences and no wrap:
- up: next = (tgt-cur <= step) ? tgt : cur+step.
- down: next = (cur-tgt <= step) ? tgt : cur-step.
REQ-020 When step==0, the next value SHALL be tgt (immediate jump, no ramp).
REQ-021 tgtld[i] SHALL take effect on the next edge in any state; if tgtld[i] coincides with SVCi, the service SHALL use the old tgt[i] while the new value is stored.
REQ-022 stepld SHALL take effect the same way; a step load coinciding with SVCi SHALL leave the current service on the old step.
REQ-023 pwmdata SHALL hold its last value when no pwmld bit is asserted.
REQ-024 At most one pwmld bit SHALL be high in any cycle.
REQ-025 attarget and busy SHALL be derived only from registered state.
REQ-026 The pwmld pulse SHALL follow the service state by exactly 1 cycle, so a full sweep runs from tick to the last pwmld in 4 cycles.

Reset
REQ-027 While resetn is low, the block SHALL immediately force: state=IDLE, cur=0, tgt=0, step=RSTSTEP, pwmdata=0, pwmld=0, busy=0, ovr=0, pending=0, attarget=3'b111.
REQ-028 Reset asserted mid-sweep SHALL abort the sweep with no further pwmld pulses.
REQ-029 After resetn is deasserted, the first tick SHALL be honoured on the first clock edge.

Configuration
REQ-030 With macro PWM_RAMP_SCHED_TICKQ_EN defined, a tick arriving while busy SHALL set a one-deep pending flag, serviced on the IDLE cycle right after the sweep ends.
REQ-031 With PWM_RAMP_SCHED_TICKQ_EN defined, a tick arriving while pending is already set SHALL be dropped and SHALL set ovr.
REQ-032 With PWM_RAMP_SCHED_TICKQ_EN defined, ovr SHALL stay high until clrovr; if clrovr and a new overrun occur in the same cycle, set SHALL win.
REQ-033 Without PWM_RAMP_SCHED_TICKQ_EN, ticks while busy SHALL be silently dropped, ovr SHALL be tied 0, clrovr SHALL be ignored, and no pending register SHALL exist.

Verification
REQ-034 Scenario ramp up: step=8'h10, tgt0=8'h35, ticks spaced 8 cycles -> channel 0 pwmdata sequence 10,20,30,35, then no more pwmld0 and attarget[0]=1.
REQ-035 Scenario ramp down: cur1=8'h35, tgt1=8'h00, step=8'h20 -> pwmdata 15,00; no underflow to FF.
REQ-036 Scenario all channels: tgt0=8'h01, tgt1=8'h02, tgt2=8'h03, step=0, single tick -> pwmld 001,010,100 on consecutive cycles 2..4 after the tick with pwmdata 01,02,03.
REQ-037 Scenario back-to-back ticks (macro defined): ticks at cycles 0,1,2 -> one pending sweep runs immediately after the first, the third tick is dropped and ovr=1 until clrovr; with the macro undefined, exactly one sweep runs and ovr=0.
REQ-038 Scenario collision: tgtld[0] with wrtdata=8'h80 coinciding with SVC0 (old tgt 8'h40, cur 0, step 8'hFF) -> pwmdata 40; the next tick yields 80.
REQ-039 Scenario reset mid-sweep: resetn low during SVC1 -> pwmld stays 000, all outputs at reset values, and a tick after release starts a clean sweep.

Source files
------------

// File: rtl/pwm_ramp_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pwm_ramp_sched                                             |
// | Description : Three-channel PWM duty ramp scheduler. Each tick starts a   |
// |               sweep that services channels 0..2 in turn, moving cur[i]    |
// |               toward tgt[i] by at most step per tick through a single     |
// |               shared compare/adder path. A changed duty value is sent on  |
// |               pwmdata together with a one-cycle one-hot pwmld pulse.      |
// |               Optional macro PWM_RAMP_SCHED_TICKQ_EN adds a one-deep      |
// |               pending-tick queue and a sticky overrun flag (ovr).         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module pwm_ramp_sched #(
  parameter int         NCH     = 3,
  parameter logic [7:0] RSTSTEP = 8'h01
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       tick,
  input  logic [7:0] wrtdata,
  input  logic [2:0] tgtld,
  input  logic       stepld,
  input  logic       clrovr,
  output logic [7:0] pwmdata,
  output logic [2:0] pwmld,
  output logic       busy,
  output logic [2:0] attarget,
  output logic       ovr
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SVC0 = 2'd1;
  localparam logic [1:0] S_SVC1 = 2'd2;
  localparam logic [1:0] S_SVC2 = 2'd3;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [2:0] svc_oh;     // one-hot channel being serviced this cycle
  logic       start;      // begin a sweep from IDLE

  logic [7:0] cur [NCH];
  logic [7:0] tgt [NCH];
  logic [7:0] step;

  logic [7:0] sel_cur;
  logic [7:0] sel_tgt;
  logic [8:0] diff_up;
  logic [8:0] diff_dn;
  logic [7:0] next_val;
  logic       need_load;

`ifdef PWM_RAMP_SCHED_TICKQ_EN
  logic pending;

  assign start = tick | pending;

  // Pending tick queue and sticky overrun; a new overrun beats a clear
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pending <= 1'b0;
      ovr     <= 1'b0;
    end else begin
      if (state == S_IDLE) begin
        pending <= 1'b0;
      end else if (tick) begin
        pending <= 1'b1;
      end
      if (busy && tick && pending) begin
        ovr <= 1'b1;
      end else if (clrovr) begin
        ovr <= 1'b0;
      end
    end
  end
`else
  logic unused_clrovr;

  assign start         = tick;
  assign ovr           = 1'b0;
  assign unused_clrovr = clrovr;
`endif

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: fixed one-cycle-per-channel sweep
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  state_nxt = start ? S_SVC0 : S_IDLE;
      S_SVC0:  state_nxt = S_SVC1;
      S_SVC1:  state_nxt = S_SVC2;
      S_SVC2:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs decoded from the registered state only
  always_comb begin
    busy   = 1'b1;
    svc_oh = 3'b000;
    case (state)
      S_IDLE:  busy   = 1'b0;
      S_SVC0:  svc_oh = 3'b001;
      S_SVC1:  svc_oh = 3'b010;
      S_SVC2:  svc_oh = 3'b100;
      default: busy   = 1'b0;
    endcase
  end

  // Shared operand mux: pick the serviced channel's cur/tgt
  always_comb begin
    sel_cur = 8'h00;
    sel_tgt = 8'h00;
    for (int i = 0; i < NCH; i++) begin
      if (svc_oh[i]) begin
        sel_cur = cur[i];
        sel_tgt = tgt[i];
      end
    end
  end

  // Shared ramp arithmetic; 9-bit differences so the clamp never wraps
  always_comb begin
    diff_up   = {1'b0, sel_tgt} - {1'b0, sel_cur};
    diff_dn   = {1'b0, sel_cur} - {1'b0, sel_tgt};
    need_load = (svc_oh != 3'b000) && (sel_cur != sel_tgt);
    if (step == 8'h00) begin
      next_val = sel_tgt;
    end else if (sel_tgt > sel_cur) begin
      next_val = (diff_up <= {1'b0, step}) ? sel_tgt : (sel_cur + step);
    end else begin
      next_val = (diff_dn <= {1'b0, step}) ? sel_tgt : (sel_cur - step);
    end
  end

  // Channel registers; loads in the service cycle see the old tgt/step
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NCH; i++) begin
        cur[i] <= 8'h00;
        tgt[i] <= 8'h00;
      end
      step <= RSTSTEP;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (tgtld[i]) begin
          tgt[i] <= wrtdata;
        end
        if (need_load && svc_oh[i]) begin
          cur[i] <= next_val;
        end
      end
      if (stepld) begin
        step <= wrtdata;
      end
    end
  end

  // PWM load bus: one-cycle pulse after the service state, data held otherwise
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pwmdata <= 8'h00;
      pwmld   <= 3'b000;
    end else begin
      pwmld <= need_load ? svc_oh : 3'b000;
      if (need_load) begin
        pwmdata <= next_val;
      end
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_att
    assign attarget[g] = (cur[g] == tgt[g]);
  end

endmodule
`default_nettype wire
